alu_ex_stage: RTL and testbench

Execute-stage block of the pipelined MIPS core. Consumes the 4-bit ALU operation code from the ALU control unit plus ID/EX operands. Computes the ALU result and registers it with forwarded control into the EX/MEM pipeline register. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/alu_ex_stage_pkg.sv | 21 ++
 rtl/alu_ex_stage_alu_core.sv | 46 ++++
 rtl/alu_ex_stage.sv | 145 ++++++++++++++
 tb/tb_alu_ex_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_ex_stage_pkg.sv
// Shared ALU op-code constants and default widths for the EX stage and the ALU control unit.
package alu_ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1110;

  function automatic logic op_supported(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR)  || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_NOR) ||
           (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_ex_stage_alu_core.sv
// Combinational ALU: result, signed overflow (add/sub only) and illegal-op flag.
module alu_core
  import alu_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              illegal
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = !op_supported(op_code);
    case (op_code)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
      ALU_SLL: result = b << shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_ex_stage.sv
// EX stage: ALU plus EX/MEM pipeline register, 1-cycle latency.
// Edge priority is reset > flush > stall > load; flush and in_valid=0 both load a bubble.
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal_op,
  output logic [DATA_W-1:0] store_data_q,
  output logic [REG_AW-1:0] dest_reg_q,
  output logic              reg_write_q,
  output logic              mem_read_q,
  output logic              mem_write_q,
  output logic              mem_to_reg_q
);

  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_ill;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op_code  (op_code),
    .a        (src_a),
    .b        (src_b),
    .shamt    (shamt),
    .result   (alu_res),
    .overflow (alu_ovf),
    .illegal  (alu_ill)
  );

  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] result_q,    result_d;
  logic              zero_q,      zero_d;
  logic              ovf_q,       ovf_d;
  logic              ill_q,       ill_d;
  logic [DATA_W-1:0] sdata_q,     sdata_d;
  logic [REG_AW-1:0] dest_q,      dest_d;
  logic              rw_q,        rw_d;
  logic              mr_q,        mr_d;
  logic              mw_q,        mw_d;
  logic              m2r_q,       m2r_d;

  always_comb begin
    valid_d  = 1'b0;
    result_d = '0;
    zero_d   = 1'b0;
    ovf_d    = 1'b0;
    ill_d    = 1'b0;
    sdata_d  = '0;
    dest_d   = '0;
    rw_d     = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    m2r_d    = 1'b0;
    if (flush) begin
      // bubble: defaults already zero
    end else if (stall) begin
      valid_d  = valid_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
      sdata_d  = sdata_q;
      dest_d   = dest_q;
      rw_d     = rw_q;
      mr_d     = mr_q;
      mw_d     = mw_q;
      m2r_d    = m2r_q;
    end else if (in_valid) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      ovf_d    = alu_ovf;
      ill_d    = alu_ill;
      sdata_d  = store_data;
      dest_d   = dest_reg;
      // an unknown op must not corrupt architectural state
      rw_d     = reg_write & ~alu_ill;
      mw_d     = mem_write & ~alu_ill;
      mr_d     = mem_read;
      m2r_d    = mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      sdata_q  <= '0;
      dest_q   <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      m2r_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      sdata_q  <= sdata_d;
      dest_q   <= dest_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      m2r_q    <= m2r_d;
    end
  end

  assign out_valid    = valid_q;
  assign alu_result   = result_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign illegal_op   = ill_q;
  assign store_data_q = sdata_q;
  assign dest_reg_q   = dest_q;
  assign reg_write_q  = rw_q;
  assign mem_read_q   = mr_q;
  assign mem_write_q  = mw_q;
  assign mem_to_reg_q = m2r_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with hand-computed expectations.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [3:0]  op_code;
  logic [31:0] src_a, src_b, store_data;
  logic [4:0]  shamt, dest_reg;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic        out_valid, zero, overflow, illegal_op;
  logic [31:0] alu_result, store_data_q;
  logic [4:0]  dest_reg_q;
  logic        reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .op_code      (op_code),
    .src_a        (src_a),
    .src_b        (src_b),
    .shamt        (shamt),
    .store_data   (store_data),
    .dest_reg     (dest_reg),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .out_valid    (out_valid),
    .alu_result   (alu_result),
    .zero         (zero),
    .overflow     (overflow),
    .illegal_op   (illegal_op),
    .store_data_q (store_data_q),
    .dest_reg_q   (dest_reg_q),
    .reg_write_q  (reg_write_q),
    .mem_read_q   (mem_read_q),
    .mem_write_q  (mem_write_q),
    .mem_to_reg_q (mem_to_reg_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    op_code = op;
    src_a   = a;
    src_b   = b;
    shamt   = sh;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_result"}, alu_result, 32'd0);
    chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_ill"}, {31'd0, illegal_op}, 32'd0);
    chk({tag, "_sdata"}, store_data_q, 32'd0);
    chk({tag, "_dest"}, {27'd0, dest_reg_q}, 32'd0);
    chk({tag, "_ctl"}, {28'd0, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
    store_data = 32'h0000_00AA; dest_reg = 5'd3;
    reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    drive(4'b0010, 32'd5, 32'd7, 5'd0);
    tick();
    tick();
    chk_bubble("reset");

    reset = 1'b0;
    tick();
    chk("add_result", alu_result, 32'd12);
    chk("add_zero", {31'd0, zero}, 32'd0);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_dest", {27'd0, dest_reg_q}, 32'd3);
    chk("add_sdata", store_data_q, 32'h0000_00AA);
    chk("add_rw", {31'd0, reg_write_q}, 32'd1);

    drive(4'b0110, 32'd9, 32'd9, 5'd0);
    tick();
    chk("sub_eq_result", alu_result, 32'd0);
    chk("sub_eq_zero", {31'd0, zero}, 32'd1);
    chk("sub_eq_ovf", {31'd0, overflow}, 32'd0);

    drive(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0);
    tick();
    chk("add_ovf_result", alu_result, 32'h8000_0000);
    chk("add_ovf_flag", {31'd0, overflow}, 32'd1);
    chk("add_ovf_rw", {31'd0, reg_write_q}, 32'd1);

    drive(4'b0110, 32'h8000_0000, 32'd1, 5'd0);
    tick();
    chk("sub_ovf_result", alu_result, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", {31'd0, overflow}, 32'd1);

    drive(4'b0000, 32'hFFFF_FFFF, 32'h8000_0001, 5'd0);
    tick();
    chk("and_result", alu_result, 32'h8000_0001);
    chk("and_ovf", {31'd0, overflow}, 32'd0);

    drive(4'b0001, 32'h0000_F000, 32'h0000_000F, 5'd0);
    tick();
    chk("or_result", alu_result, 32'h0000_F00F);

    drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    tick();
    chk("slt_neg_result", alu_result, 32'd1);

    drive(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0);
    tick();
    chk("slt_pos_result", alu_result, 32'd0);
    chk("slt_pos_zero", {31'd0, zero}, 32'd1);

    drive(4'b1100, 32'h0F0F_0000, 32'h0000_00FF, 5'd0);
    tick();
    chk("nor_result", alu_result, 32'hF0F0_FF00);

    drive(4'b1110, 32'h1234_5678, 32'd3, 5'd4);
    tick();
    chk("sll_result", alu_result, 32'h0000_0030);

    drive(4'b1110, 32'h1234_5678, 32'd3, 5'd0);
    tick();
    chk("sll0_result", alu_result, 32'd3);

    drive(4'b0010, 32'd5, 32'd7, 5'd0);
    dest_reg = 5'd9; store_data = 32'hDEAD_BEEF;
    tick();
    chk("pre_stall_result", alu_result, 32'd12);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0110, 32'd100 + i, 32'd1, 5'd0);
      dest_reg = 5'd20 + 5'(i); store_data = 32'd0; reg_write = 1'b0; mem_read = 1'b1;
      tick();
      chk($sformatf("stall%0d_result", i), alu_result, 32'd12);
      chk($sformatf("stall%0d_dest", i), {27'd0, dest_reg_q}, 32'd9);
      chk($sformatf("stall%0d_ctl", i),
          {28'd0, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q}, 32'b1000);
    end
    stall = 1'b0;
    drive(4'b0010, 32'd1, 32'd2, 5'd0);
    tick();
    chk("unstall_result", alu_result, 32'd3);
    chk("unstall_dest", {27'd0, dest_reg_q}, 32'd22);
    chk("unstall_mr", {31'd0, mem_read_q}, 32'd1);

    stall = 1'b1; flush = 1'b1; reg_write = 1'b1;
    tick();
    chk_bubble("flush_stall");
    stall = 1'b0; flush = 1'b0;

    drive(4'b0010, 32'd5, 32'd7, 5'd0);
    in_valid = 1'b0; reg_write = 1'b1;
    tick();
    chk("inval_rw", {31'd0, reg_write_q}, 32'd0);
    chk("inval_valid", {31'd0, out_valid}, 32'd0);
    chk("inval_result", alu_result, 32'd0);

    in_valid = 1'b1;
    drive(4'b0011, 32'd5, 32'd7, 5'd0);
    reg_write = 1'b1; mem_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; dest_reg = 5'd17;
    tick();
    chk("ill_result", alu_result, 32'd0);
    chk("ill_zero", {31'd0, zero}, 32'd1);
    chk("ill_flag", {31'd0, illegal_op}, 32'd1);
    chk("ill_rw", {31'd0, reg_write_q}, 32'd0);
    chk("ill_mw", {31'd0, mem_write_q}, 32'd0);
    chk("ill_mr_m2r", {30'd0, mem_read_q, mem_to_reg_q}, 32'b11);
    chk("ill_dest", {27'd0, dest_reg_q}, 32'd17);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);

    reset = 1'b1;
    tick();
    chk_bubble("reset2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
